// File: rtl/pxs_stream_pkg.sv
// Shared definitions for the pixel-stream text stage: stream field layout,
// host command op codes and the blank character code.
package pxs_stream_pkg;

  // 26-bit pixel stream layout
  localparam int STR_W   = 26;
  localparam int ACT_BIT = 0;
  localparam int VS_BIT  = 1;
  localparam int HS_BIT  = 2;
  localparam int YC_LSB  = 3;
  localparam int YC_MSB  = 12;
  localparam int XC_LSB  = 13;
  localparam int XC_MSB  = 22;
  localparam int RGB_LSB = 23;
  localparam int RGB_MSB = 25;

  // Host command op codes
  typedef enum logic [1:0] {
    OP_PUT    = 2'b00,
    OP_NL     = 2'b01,
    OP_CLR    = 2'b10,
    OP_SETCUR = 2'b11
  } cmd_op_e;

  // Controller states: blanking the buffer, or serving host commands
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } text_state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;

  // Beam X coordinate carried in a stream word
  function automatic logic [9:0] str_xc(input logic [STR_W-1:0] s);
    return s[XC_MSB:XC_LSB];
  endfunction

  // Beam Y coordinate carried in a stream word
  function automatic logic [9:0] str_yc(input logic [STR_W-1:0] s);
    return s[YC_MSB:YC_LSB];
  endfunction

endpackage

// File: rtl/pxs_text_ram.sv
// Character buffer: simple dual-port RAM, one write port and one
// synchronous read-first read port, kept reset-free for block RAM mapping.
module pxs_text_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Write and registered read share one edge; the read sees the old word
  // NOTE: no reset on the storage array -- a reset would stop the tools from
  // mapping it to block RAM; the controller blanks it by sequencing writes.
  // NOTE: non-blocking assignments here make the same-address read return the
  // pre-write contents (read-first) and keep flop updates race-free.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/pxs_text_ctrl.sv
// Text-window controller: owns the character buffer, the host command FSM
// and cursor, and a 2-stage lookup pipeline that tags every stream pixel
// with the character under the beam and that cell's pixel origin.
module pxs_text_ctrl
  import pxs_stream_pkg::*;
#(
  parameter  int COLS       = 16,
  parameter  int ROWS       = 2,
  parameter  int SCALE_LOG2 = 0,
  localparam int N          = COLS * ROWS,
  localparam int AW         = $clog2(N)
) (
  input  logic              px_clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic [9:0]        win_x,
  input  logic [9:0]        win_y,
  input  logic [STR_W-1:0]  RGBStr_i,
  output logic [STR_W-1:0]  RGBStr_o,
  output logic [7:0]        character,
  output logic [9:0]        char_x,
  output logic [9:0]        char_y,
  output logic              in_text,
  output logic [AW-1:0]     cursor
);

  // Cell edge is 8<<SCALE_LOG2 pixels; window extent in 11-bit arithmetic
  localparam int          CELL_SH = 3 + SCALE_LOG2;
  localparam logic [10:0] WIN_W   = 11'(COLS << CELL_SH);
  localparam logic [10:0] WIN_H   = 11'(ROWS << CELL_SH);

  // ---------------------------------------------------------------------
  // Command FSM, cursor and buffer write port
  // ---------------------------------------------------------------------
  text_state_e   state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          cmd_ready_q, cmd_ready_d;

  cmd_op_e       op;
  logic          cmd_fire;
  logic [AW-1:0] nl_cursor;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign op       = cmd_op_e'(cmd_op);
  assign cmd_fire = cmd_valid & cmd_ready_q;

  // Start of the row after the cursor's row, wrapping past the last row
  assign nl_cursor = AW'(((int'(cursor_q) / COLS + 1) % ROWS) * COLS);

  // Next-state, cursor and write-port selection
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; a missed path would infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cursor_d  = cursor_q;
    wr_en     = 1'b0;
    wr_addr   = cursor_q;
    wr_data   = cmd_data;

    unique case (state_q)
      ST_CLEAR: begin
        // Blank one cell per cycle; commands are refused until done
        wr_en    = 1'b1;
        wr_addr  = clr_cnt_q;
        wr_data  = CH_SPACE;
        cursor_d = '0;
        if (clr_cnt_q == AW'(N - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (cmd_fire) begin
          unique case (op)
            OP_PUT: begin
              wr_en    = 1'b1;
              cursor_d = cursor_q + AW'(1);
            end
            OP_NL: begin
              cursor_d = nl_cursor;
            end
            OP_SETCUR: begin
              cursor_d = cmd_data[AW-1:0];
            end
            OP_CLR: begin
              cursor_d  = '0;
              clr_cnt_d = '0;
              state_d   = ST_CLEAR;
            end
          endcase
        end
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Control state registers; reset restarts the blanking sequence from 0
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      cursor_q    <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      cursor_q    <= cursor_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cursor    = cursor_q;

  // ---------------------------------------------------------------------
  // Stage 0 inputs: window hit test and cell address from the beam position
  // ---------------------------------------------------------------------
  logic [9:0]    xc, yc;
  logic [10:0]   x_off, y_off;
  logic [10:0]   col, row;
  logic          hit_x, hit_y;
  logic          in_text_d;
  logic [AW-1:0] rd_addr_d;
  logic [9:0]    char_x_d, char_y_d;

  // Hit test and address/origin arithmetic, widened so a window running past
  // 1023 clips at the screen edge rather than wrapping back to column 0
  always_comb begin
    xc    = str_xc(RGBStr_i);
    yc    = str_yc(RGBStr_i);
    x_off = {1'b0, xc} - {1'b0, win_x};
    y_off = {1'b0, yc} - {1'b0, win_y};
    hit_x = ({1'b0, xc} >= {1'b0, win_x}) && ({1'b0, xc} < ({1'b0, win_x} + WIN_W));
    hit_y = ({1'b0, yc} >= {1'b0, win_y}) && ({1'b0, yc} < ({1'b0, win_y} + WIN_H));
    col   = x_off >> CELL_SH;
    row   = y_off >> CELL_SH;

    in_text_d = hit_x && hit_y;
    rd_addr_d = '0;
    char_x_d  = '0;
    char_y_d  = '0;
    if (in_text_d) begin
      rd_addr_d = AW'(int'(row) * COLS + int'(col));
      char_x_d  = win_x + 10'(col << CELL_SH);
      char_y_d  = win_y + 10'(row << CELL_SH);
    end
  end

  // ---------------------------------------------------------------------
  // Two-stage pipeline: stage 0 registers the lookup, stage 1 lines the
  // side-band up with the synchronous RAM read
  // ---------------------------------------------------------------------
  logic [AW-1:0]    rd_addr_q;
  logic             in_text_s0_q, in_text_s1_q;
  logic [9:0]       char_x_s0_q, char_x_s1_q;
  logic [9:0]       char_y_s0_q, char_y_s1_q;
  logic [STR_W-1:0] str_s0_q, str_s1_q;
  logic [7:0]       rd_data;

  // Pipeline registers for address, window flag, cell origin and stream
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q    <= '0;
      in_text_s0_q <= 1'b0;
      char_x_s0_q  <= '0;
      char_y_s0_q  <= '0;
      str_s0_q     <= '0;
      in_text_s1_q <= 1'b0;
      char_x_s1_q  <= '0;
      char_y_s1_q  <= '0;
      str_s1_q     <= '0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      in_text_s0_q <= in_text_d;
      char_x_s0_q  <= char_x_d;
      char_y_s0_q  <= char_y_d;
      str_s0_q     <= RGBStr_i;
      in_text_s1_q <= in_text_s0_q;
      char_x_s1_q  <= char_x_s0_q;
      char_y_s1_q  <= char_y_s0_q;
      str_s1_q     <= str_s0_q;
    end
  end

  pxs_text_ram #(
    .DEPTH (N),
    .AW    (AW)
  ) u_ram (
    .clk     (px_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  // Outside the window the RAM word is meaningless, so show a blank
  assign character = in_text_s1_q ? rd_data : CH_SPACE;
  assign char_x    = char_x_s1_q;
  assign char_y    = char_y_s1_q;
  assign in_text   = in_text_s1_q;
  assign RGBStr_o  = str_s1_q;

endmodule

// File: tb/tb_pxs_text_ctrl.sv
// Bench for pxs_text_ctrl (COLS=16, ROWS=2, 8-pixel cells, window at
// (100,50)). Stimulus pushes hand-computed expectations into a queue; a
// monitor pops and compares whenever an Active pixel leaves the DUT.
module tb_pxs_text_ctrl;
  import pxs_stream_pkg::*;

  localparam int AW = 5;

  logic              px_clk = 1'b0;
  logic              rst_n  = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_data;
  logic [9:0]        win_x, win_y;
  logic [STR_W-1:0]  RGBStr_i, RGBStr_o;
  logic [7:0]        character;
  logic [9:0]        char_x, char_y;
  logic              in_text;
  logic [AW-1:0]     cursor;

  typedef struct {
    logic [STR_W-1:0] str;
    logic [7:0]       ch;
    logic [9:0]       cx;
    logic [9:0]       cy;
    logic             in_t;
    int               due;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   tag      = 0;

  pxs_text_ctrl #(
    .COLS       (16),
    .ROWS       (2),
    .SCALE_LOG2 (0)
  ) dut (
    .px_clk    (px_clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .win_x     (win_x),
    .win_y     (win_y),
    .RGBStr_i  (RGBStr_i),
    .RGBStr_o  (RGBStr_o),
    .character (character),
    .char_x    (char_x),
    .char_y    (char_y),
    .in_text   (in_text),
    .cursor    (cursor)
  );

  always #5 px_clk = ~px_clk;

  always @(posedge px_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [STR_W-1:0] mk_str(input logic [9:0] x, input logic [9:0] y, input int t);
    logic [STR_W-1:0] s;
    s = '0;
    s[ACT_BIT]         = 1'b1;
    s[VS_BIT]          = t[0];
    s[HS_BIT]          = t[1];
    s[YC_MSB:YC_LSB]   = y;
    s[XC_MSB:XC_LSB]   = x;
    s[RGB_MSB:RGB_LSB] = t[4:2];
    return s;
  endfunction

  // Drive one Active pixel for one cycle and queue what must come out 2 cycles later
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] ch,
                     input logic [9:0] cx, input logic [9:0] cy, input logic in_t);
    exp_t e;
    tag++;
    RGBStr_i = mk_str(x, y, tag);
    e.str  = RGBStr_i;
    e.ch   = ch;
    e.cx   = cx;
    e.cy   = cy;
    e.in_t = in_t;
    e.due  = cyc + 2;
    e.id   = tag;
    exp_q.push_back(e);
    @(posedge px_clk); #1;
    RGBStr_i = '0;
  endtask

  task automatic send_cmd(input cmd_op_e op, input logic [7:0] data);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge px_clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, expected 1", guard);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge px_clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  // Edges from now until cmd_ready rises must equal the buffer size
  task automatic count_low(input string name);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge px_clk); #1;
      n++;
    end
    check(name, n, 32);
  endtask

  task automatic check_reset(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 0);
    check({p, "_RGBStr_o"},  RGBStr_o,  0);
    check({p, "_character"}, character, 8'h20);
    check({p, "_char_x"},    char_x,    0);
    check({p, "_char_y"},    char_y,    0);
    check({p, "_in_text"},   in_text,   0);
    check({p, "_cursor"},    cursor,    0);
  endtask

  // Scoreboard monitor: compare every Active pixel leaving the DUT
  always @(negedge px_clk) begin
    exp_t e;
    if (rst_n && RGBStr_o[ACT_BIT]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pixel: got stream 0x%0h, expected no Active pixel", RGBStr_o);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pix%0d_latency",   e.id), cyc,       e.due);
        check($sformatf("pix%0d_stream",    e.id), RGBStr_o,  e.str);
        check($sformatf("pix%0d_character", e.id), character, e.ch);
        check($sformatf("pix%0d_char_x",    e.id), char_x,    e.cx);
        check($sformatf("pix%0d_char_y",    e.id), char_y,    e.cy);
        check($sformatf("pix%0d_in_text",   e.id), in_text,   e.in_t);
      end
    end
  end

  initial begin
    int n;
    win_x     = 10'd100;
    win_y     = 10'd50;
    RGBStr_i  = '0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;

    // Reset values, then the automatic 32-cycle blanking
    repeat (3) @(posedge px_clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    count_low("por_clear_len");

    // Whole window reads blank after the auto-clear
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        pix(10'(100 + 8 * c), 10'(50 + 8 * r), 8'h20, 10'(100 + 8 * c), 10'(50 + 8 * r), 1'b1);
      end
    end

    // PUT 'A','B' then look them up
    send_cmd(OP_PUT, 8'h41);
    send_cmd(OP_PUT, 8'h42);
    check("cursor_after_AB", cursor, 2);
    pix(10'd108, 10'd50, 8'h42, 10'd108, 10'd50, 1'b1);
    pix(10'd100, 10'd50, 8'h41, 10'd100, 10'd50, 1'b1);
    pix(10'd115, 10'd57, 8'h42, 10'd108, 10'd50, 1'b1);

    // Window edges, with 'Q' placed in column 15 of row 0
    send_cmd(OP_SETCUR, 8'd15);
    send_cmd(OP_PUT, 8'h51);
    check("cursor_after_Q", cursor, 16);
    pix(10'd99,  10'd50, 8'h20, 10'd0,   10'd0,  1'b0);
    pix(10'd227, 10'd50, 8'h51, 10'd220, 10'd50, 1'b1);
    pix(10'd220, 10'd50, 8'h51, 10'd220, 10'd50, 1'b1);
    pix(10'd228, 10'd50, 8'h20, 10'd0,   10'd0,  1'b0);
    pix(10'd108, 10'd66, 8'h20, 10'd0,   10'd0,  1'b0);
    pix(10'd108, 10'd65, 8'h20, 10'd108, 10'd58, 1'b1);
    pix(10'd108, 10'd49, 8'h20, 10'd0,   10'd0,  1'b0);

    // Cursor rules
    send_cmd(OP_SETCUR, 8'd31);
    send_cmd(OP_PUT, 8'h45);
    check("cursor_wrap", cursor, 0);
    pix(10'd227, 10'd65, 8'h45, 10'd220, 10'd58, 1'b1);
    send_cmd(OP_SETCUR, 8'd5);
    send_cmd(OP_NL, 8'h00);
    check("cursor_nl_row0", cursor, 16);
    send_cmd(OP_SETCUR, 8'd20);
    send_cmd(OP_NL, 8'h00);
    check("cursor_nl_row1", cursor, 0);

    // Collision: PUT 'Z' to cell 2 on the edge that reads cell 2
    send_cmd(OP_SETCUR, 8'd2);
    pix(10'd116, 10'd50, 8'h20, 10'd116, 10'd50, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUT;
    cmd_data  = 8'h5A;
    pix(10'd117, 10'd50, 8'h5A, 10'd116, 10'd50, 1'b1);
    cmd_valid = 1'b0;
    check("cursor_after_Z", cursor, 3);
    pix(10'd119, 10'd50, 8'h5A, 10'd116, 10'd50, 1'b1);

    // CLEAR while streaming: 32 cycles busy, stream latency unchanged
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    cmd_data  = 8'h00;
    pix(10'd180, 10'd50, 8'h20, 10'd180, 10'd50, 1'b1);
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      if (n % 2 == 1) pix(10'd180, 10'd50, 8'h20, 10'd180, 10'd50, 1'b1);
      else            pix(10'(n), 10'd0, 8'h20, 10'd0, 10'd0, 1'b0);
      n++;
    end
    check("clr_stream_len", n, 32);
    check("cursor_after_clr", cursor, 0);
    pix(10'd108, 10'd50, 8'h20, 10'd108, 10'd50, 1'b1);
    pix(10'd116, 10'd50, 8'h20, 10'd116, 10'd50, 1'b1);

    // Reset at clr_cnt = 10; cell 31 holds 'M' and is only blanked by a full rerun
    send_cmd(OP_SETCUR, 8'd31);
    send_cmd(OP_PUT, 8'h4D);
    pix(10'd227, 10'd65, 8'h4D, 10'd220, 10'd58, 1'b1);
    send_cmd(OP_CLR, 8'h00);
    RGBStr_i = mk_str(10'd108, 10'd50, 0);
    RGBStr_i[ACT_BIT] = 1'b0;
    repeat (10) begin
      @(posedge px_clk); #1;
    end
    check("pre_rst_in_text", in_text, 1);
    check("pre_rst_char_x", char_x, 108);
    check("pre_rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset("mid_clear");
    @(posedge px_clk); #1;
    RGBStr_i = '0;
    rst_n = 1'b1;
    count_low("restart_clear_len");
    pix(10'd227, 10'd65, 8'h20, 10'd220, 10'd58, 1'b1);

    repeat (4) begin
      @(posedge px_clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pxs_text_ctrl.md
# pxs_text_ctrl

Text-window controller that sequences the character-drawing stage of the pixel-stream pipeline. It holds a COLS×ROWS character buffer that a host fills through a valid/ready command port. For every pixel of the incoming 26-bit RGB stream, it looks up the character under the beam. It emits that character and its cell origin, stream-aligned, so the downstream single-character drawer renders a full text window instead of one fixed glyph.

## Interface
- COLS, 16: characters per row (power of 2).
- ROWS, 2: text rows (power of 2).
- SCALE_LOG2, 0: cell size is (8<<SCALE_LOG2) pixels square.
- N = COLS*ROWS (localparam); AW = $clog2(N).

- px_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 PUT, 01 NEWLINE, 10 CLEAR, 11 SETCUR.
- cmd_data  in  8  character code (PUT) or cursor index in [AW-1:0] (SETCUR).
- win_x, win_y  in  10 each  window top-left pixel; sampled every cycle.
- RGBStr_i  in  26  stream: Active[0], VS[1], HS[2], YC[12:3], XC[22:13], RGB[25:23].
- RGBStr_o  out  26  RGBStr_i delayed 2 cycles, unmodified.
- character  out  8  code under the beam; 0x20 outside the window.
- char_x, char_y  out  10 each  pixel origin of the current cell; 0 outside the window.
- in_text  out  1  beam is inside the window.
- cursor  out  AW  next write index.

## Operation
- Window hit: win_x ≤ XC < win_x + COLS·(8<<SCALE_LOG2), and the same rule applies to YC with ROWS. Widen to 11 bits before comparing; a window extending past 1023 clips and does not wrap.
- col = (XC−win_x) >> (3+SCALE_LOG2); row likewise on Y. Read address = row·COLS + col.
- char_x = win_x + (col << (3+SCALE_LOG2)); char_y likewise on Y.
- States: CLEAR and IDLE.
- CLEAR: writes 0x20 to address clr_cnt = 0…N−1, one per cycle. cmd_ready = 0. After address N−1 → IDLE. cursor is held at 0.
- IDLE: cmd_ready = 1. A command is accepted on a cycle with cmd_valid & cmd_ready.
- PUT: buffer[cursor] ← cmd_data, then cursor ← cursor+1. Going from N−1 wraps to 0.
- NEWLINE: cursor ← (row+1 mod ROWS)·COLS, where row is the cursor's row.
- SETCUR: cursor ← cmd_data[AW-1:0].
- CLEAR command: cursor ← 0, clr_cnt ← 0, then → CLEAR.
- Reset enters CLEAR, so the buffer is blanked automatically after every reset.
- Read/write collision: a pixel read and a host write to the same address in the same cycle return the old value (read-first).
- Reset asserted mid-CLEAR or mid-command: the sequence aborts and restarts CLEAR from 0 after release.

## Timing
- Stage 0: register the address, in_text, char_x, char_y and the stream.
- Stage 1: synchronous RAM read; all outputs are valid together.
- Total latency from RGBStr_i to every output is exactly 2 cycles.
- Command writes take effect at the accepting edge. A pixel read issued on a later cycle sees the new value.
- The CLEAR sequence holds cmd_ready low for exactly N cycles, starting the cycle after acceptance or reset release.
- Reset values:
  - RGBStr_o = 0.
  - character = 0x20.
  - char_x, char_y = 0.
  - in_text = 0.
  - cursor = 0.
  - cmd_ready = 0, because the controller is in CLEAR.
  - pipeline registers = 0.

## Structure
- Package pxs_stream_pkg holds:
  - the stream field bit positions (Active, VS, HS, YC, XC, RGB);
  - the op codes OP_PUT, OP_NL, OP_CLR, OP_SETCUR;
  - the constant CH_SPACE = 8'h20.
- Sub-module pxs_text_ram: N×8 simple dual-port RAM with one write port, one synchronous read port and read-first behaviour. It carries no reset, so that it maps to block RAM.
- The FSM, cursor, address arithmetic and stream pipeline stay in pxs_text_ctrl.

## Test plan
- Reset and auto-clear:
  - Stimulus: release rst_n; check cmd_ready.
  - Required: cmd_ready stays 0 for 32 cycles (COLS=16, ROWS=2), then goes 1.
  - Required: a scan of the whole window reads 0x20 at every cell.
- PUT and lookup:
  - Stimulus: win=(100,50); PUT 'A','B'; drive XC=108, YC=50.
  - Required: 2 cycles later character = 'B', char_x = 108, char_y = 50, in_text = 1.
- Window edges:
  - XC=99 → in_text = 0, character = 0x20.
  - XC=227 → in_text = 1, col = 15.
  - XC=228 → in_text = 0.
  - YC=66 → in_text = 0.
- Cursor rules:
  - SETCUR 31, then PUT → cursor = 0.
  - SETCUR 5, then NEWLINE → cursor = 16.
  - SETCUR 20, then NEWLINE → cursor = 0.
- Collision and CLEAR mid-frame:
  - Stimulus: PUT 'Z' at the address being read in the same cycle.
  - Required: the read returns the old value, and the next read returns 'Z'.
  - Stimulus: issue CLEAR while streaming.
  - Required: cmd_ready is low for 32 cycles and RGBStr_o keeps its 2-cycle latency.
- Reset mid-CLEAR:
  - Stimulus: assert rst_n low at clr_cnt = 10.
  - Required: all outputs take their reset values immediately, and a full 32-cycle CLEAR runs again after release.
